// File: rtl/uart_tx_queue.sv
// Byte FIFO that drains itself into a UART transmitter en/data_in/rdy handshake.
// Optional `flush` input is compiled in when UART_TXQ_FLUSH_EN is defined.
module uart_tx_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
`ifdef UART_TXQ_FLUSH_EN
    input  logic          flush,
`endif
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          tx_rdy,
    output logic          tx_en,
    output logic [7:0]    tx_data
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        READY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rp;
    logic [AW-1:0]   wp;
    logic [CW-1:0]   count_nxt;
    logic            push;
    logic            pop;
    logic            tx_en_nxt;
    logic            flush_req;

`ifdef UART_TXQ_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Full check uses the registered flag, so a push is rejected even if a pop frees a slot this cycle.
    assign push = wr_en && !full && !flush_req;

    // Drain FSM: one pop per transmitter-ready window, always followed by an idle cycle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_en_nxt = 1'b0;
        case (state)
            READY: begin
                if (!empty && tx_rdy) begin
                    pop       = 1'b1;
                    tx_en_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD:    state_nxt = READY;
            default: state_nxt = READY;
        endcase
        if (flush_req) begin
            pop       = 1'b0;
            tx_en_nxt = 1'b0;
            state_nxt = READY;
        end
    end

    always_comb begin
        count_nxt = count;
        if (flush_req) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= READY;
            tx_en <= 1'b0;
        end else begin
            state <= state_nxt;
            tx_en <= tx_en_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp       <= '0;
            wp       <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            if (wr_en && full && !flush_req) begin
                overflow <= 1'b1;
            end
            if (flush_req) begin
                rp <= wp;
            end else begin
                if (push) begin
                    wp <= wp + AW'(1);
                end
                if (pop) begin
                    rp      <= rp + AW'(1);
                    tx_data <= mem[rp];
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: a queue-based model predicts accepted bytes and pop
// cycles; a negedge monitor checks every tx_en pulse against the expected queue.
module tb_uart_tx_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx_rdy = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
    logic          flush = 1'b0;
`endif
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_en;
    logic [7:0]    tx_data;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
`ifdef UART_TXQ_FLUSH_EN
        .flush    (flush),
`endif
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_rdy   (tx_rdy),
        .tx_en    (tx_en),
        .tx_data  (tx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    bit         m_hold   = 1'b0;
    bit         m_popped = 1'b0;
    bit         m_ovf    = 1'b0;
    logic [7:0] m_last   = 8'h00;
    int         cyc      = 0;
    int         busy     = 0;
    int         n_vec    = 0;
    int         n_miss   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Reference model: FIFO contents as a queue, pop allowed only when the previous edge did not pop.
    task automatic model_edge(input bit we, input logic [7:0] d, input bit rdy, input bit rs, input bit fl);
        bit   do_pop;
        bit   do_push;
        exp_t e;
        cyc++;
        if (rs) begin
            mq.delete();
            m_hold = 1'b0; m_popped = 1'b0; m_ovf = 1'b0; m_last = 8'h00;
        end else if (fl) begin
            mq.delete();
            m_hold = 1'b0; m_popped = 1'b0;
        end else begin
            do_pop  = !m_hold && (mq.size() > 0) && rdy;
            do_push = we && (mq.size() < int'(DEPTH));
            if (we && !do_push) m_ovf = 1'b1;
            m_popped = do_pop;
            m_hold   = do_pop;
            if (do_pop) begin
                m_last = mq.pop_front();
                e.cyc  = cyc;
                e.data = m_last;
                exp_q.push_back(e);
                busy = 10;
            end
            if (do_push) mq.push_back(d);
        end
    endtask

    task automatic check_status();
        chk("count",    int'(count),    mq.size());
        chk("full",     int'(full),     int'(mq.size() == int'(DEPTH)));
        chk("empty",    int'(empty),    int'(mq.size() == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("tx_data",  int'(tx_data),  int'(m_last));
        chk("tx_en",    int'(tx_en),    int'(m_popped));
    endtask

    task automatic step(input bit we, input logic [7:0] d, input bit rdy, input bit rs = 1'b0,
                        input bit fl = 1'b0);
        wr_en   = we;
        wr_data = d;
        tx_rdy  = rdy;
        rst     = rs;
`ifdef UART_TXQ_FLUSH_EN
        flush   = fl;
`endif
        @(posedge clk);
        if (busy > 0) busy--;
        model_edge(we, d, rdy, rs, fl);
        #1;
        check_status();
    endtask

    // Drains with a transmitter that drops rdy for 10 cycles after each pulse.
    task automatic drain();
        for (int i = 0; i < 600 && (mq.size() > 0 || m_hold); i++) begin
            step(1'b0, 8'h00, busy == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        chk("drained", mq.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (tx_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_tx_en at cycle %0d: got pulse with data %0h, expected no pulse",
                         cyc, tx_data);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_data", int'(tx_data), int'(e.data));
            end
        end
    end

    initial begin
        int pushed;

        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Basic drain
        step(1'b1, 8'h41, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

        // Burst of 16 with transmitter blocked, then one rejected push
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h41 + i), 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        busy = 0;
        drain();

        // Simultaneous push/pop at count 3, then at full
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i < 40 && mq.size() < int'(DEPTH); i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'($urandom), 1'b1);
        busy = 0;
        drain();

        // Wrap-around: 40 bytes with low occupancy
        pushed = 0;
        for (int i = 0; i < 600 && (pushed < 40 || mq.size() > 0); i++) begin
            bit we;
            we = (pushed < 40) && (mq.size() < 5) && ($urandom_range(0, 3) != 0);
            if (we) pushed++;
            step(we, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();

        // Random traffic including overflow attempts
        for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0));
        drain();

        // Reset with 5 queued bytes
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h7E, 1'b1);
        drain();

`ifdef UART_TXQ_FLUSH_EN
        // Flush with 5 queued bytes and overflow already set
        for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 100 && mq.size() > 5; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h6C, 1'b1);
        drain();
`endif

        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
